// File: rtl/crc_frame_pkg.sv
// Shared types and helpers for the CRC frame serializer and its reference model.
// Latency: n/a (package only).
// Backpressure: n/a.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        PRE  = 2'd3
    } state_t;

    localparam logic [7:0] PREAMBLE = 8'hA5;
    localparam int         PRE_W    = 8;

    // One MSB-first CRC step on a register of 'width' bits (2..32), no reflection.
    function automatic logic [31:0] crc_step(
        input logic [31:0] crc,
        input logic        din,
        input logic [31:0] poly,
        input int          width
    );
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = crc[5'(width - 1)] ^ din;
        return ((crc << 1) ^ (fb ? poly : 32'd0)) & mask;
    endfunction

endpackage

// File: rtl/crc_lfsr_serial.sv
// Serial MSB-first CRC register with init, enable and freeze controls.
// Latency: value reflects an input bit one clock after it is presented with enable.
// Backpressure: none; freeze holds the value, and init+enable seeds and steps in one edge.
module crc_lfsr_serial
    import crc_frame_pkg::*;
#(
    parameter int             CRC_W    = 16,
    parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021,
    parameter logic [CRC_W-1:0] CRC_INIT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             init,
    input  logic             enable,
    input  logic             freeze,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] base;
    logic [CRC_W-1:0] crc_nxt;

    // Step from the init value when seeding and stepping on the same edge.
    always_comb begin
        base    = init ? CRC_INIT : crc;
        crc_nxt = CRC_W'(crc_step(32'(base), din, 32'(CRC_POLY), CRC_W));
    end

    // CRC register: freeze wins over enable so the value stays put while it is shifted out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc <= '0;
        end else if (enable && !freeze) begin
            crc <= crc_nxt;
        end else if (init) begin
            crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/crc_frame_serializer.sv
// Latches a payload, shifts it out MSB first while computing its CRC, optionally appends the CRC.
// Latency: start accepted at edge k gives the first valid bit in cycle k+1; done_tick one cycle after the last bit.
// Backpressure: none; start is only sampled in IDLE, busy tells the requester. Option: CRC_FRAME_PREAMBLE_EN adds an 8'hA5 preamble.
module crc_frame_serializer
    import crc_frame_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] CRC_POLY = 16'h1021,
    parameter logic [CRC_W-1:0] CRC_INIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] payload,
    output logic              busy,
    output logic              serial_valid,
    output logic              serial_out,
    output logic [CRC_W-1:0]  crc_value,
    output logic              done_tick
);

`ifdef CRC_FRAME_PREAMBLE_EN
    localparam int HDR_W = PRE_W;
`else
    localparam int HDR_W = 0;
`endif
    // The shift register holds header+payload, and is reused to shift out the CRC.
    localparam int FRM_W   = DATA_W + HDR_W;
    localparam int SH_W    = (FRM_W > CRC_W) ? FRM_W : CRC_W;
    localparam int MX1     = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int CNT_MAX = (MX1 > HDR_W) ? MX1 : HDR_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]   sreg_q, sreg_d;
    logic              mode_q, mode_d;
    logic              busy_d, valid_d, out_d, done_d;
    logic [CRC_W-1:0]  crcv_d;
    logic [SH_W-1:0]   frame_ld, crc_ld;
    logic              lfsr_init, lfsr_en, lfsr_freeze, lfsr_bit;
    logic [CRC_W-1:0]  lfsr_crc;

    crc_lfsr_serial #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) u_lfsr (
        .clk    (clk),
        .rstn   (rstn),
        .init   (lfsr_init),
        .enable (lfsr_en),
        .freeze (lfsr_freeze),
        .din    (lfsr_bit),
        .crc    (lfsr_crc)
    );

    // Next state, shift datapath and registered-output next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        mode_d      = mode_q;
        busy_d      = busy;
        valid_d     = 1'b0;
        out_d       = 1'b0;
        done_d      = 1'b0;
        crcv_d      = crc_value;
        lfsr_init   = 1'b0;
        lfsr_en     = 1'b0;
        lfsr_freeze = 1'b0;
        lfsr_bit    = sreg_q[SH_W-1];
`ifdef CRC_FRAME_PREAMBLE_EN
        frame_ld    = SH_W'({PREAMBLE, payload}) << (SH_W - FRM_W);
`else
        frame_ld    = SH_W'(payload) << (SH_W - FRM_W);
`endif
        crc_ld      = SH_W'(lfsr_crc) << (SH_W - CRC_W);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    out_d     = frame_ld[SH_W-1];
                    sreg_d    = frame_ld << 1;
                    cnt_d     = CNT_W'(1);
                    lfsr_init = 1'b1;
                    lfsr_bit  = frame_ld[SH_W-1];
`ifdef CRC_FRAME_PREAMBLE_EN
                    state_d   = PRE;
`else
                    state_d   = DATA;
                    lfsr_en   = 1'b1;
`endif
                end
            end
`ifdef CRC_FRAME_PREAMBLE_EN
            PRE: begin
                valid_d = 1'b1;
                out_d   = sreg_q[SH_W-1];
                sreg_d  = sreg_q << 1;
                if (cnt_q == CNT_W'(PRE_W)) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(1);
                    lfsr_en = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`endif
            DATA: begin
                if (cnt_q == CNT_W'(DATA_W)) begin
                    if (mode_q) begin
                        state_d = CRC;
                        valid_d = 1'b1;
                        out_d   = lfsr_crc[CRC_W-1];
                        sreg_d  = crc_ld << 1;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        crcv_d  = lfsr_crc;
                    end
                end else begin
                    valid_d = 1'b1;
                    out_d   = sreg_q[SH_W-1];
                    sreg_d  = sreg_q << 1;
                    lfsr_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            CRC: begin
                lfsr_freeze = 1'b1;
                if (cnt_q == CNT_W'(CRC_W)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    crcv_d  = lfsr_crc;
                end else begin
                    valid_d = 1'b1;
                    out_d   = sreg_q[SH_W-1];
                    sreg_d  = sreg_q << 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            mode_q       <= 1'b0;
            busy         <= 1'b0;
            serial_valid <= 1'b0;
            serial_out   <= 1'b0;
            done_tick    <= 1'b0;
            crc_value    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            mode_q       <= mode_d;
            busy         <= busy_d;
            serial_valid <= valid_d;
            serial_out   <= out_d;
            done_tick    <= done_d;
            crc_value    <= crcv_d;
        end
    end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Bench for crc_frame_serializer: directed frames with CRC_INIT=0, random back-to-back frames at defaults, mid-frame reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_crc_frame_serializer;
    import crc_frame_pkg::*;

`ifdef CRC_FRAME_PREAMBLE_EN
    localparam int HDR = 8;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        s0, m0, s1, m1;
    logic [31:0] p0, p1;
    logic        b0, v0, o0, d0, b1, v1, o1, d1;
    logic [15:0] c0, c1;
    logic        sel;
    logic [3:0]  obs_vec;
    logic [15:0] obs_crc;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          exp_bits[$];
    logic [15:0] exp_crc;

    always #5 clk = ~clk;

    crc_frame_serializer #(
        .DATA_W(32), .CRC_W(16), .CRC_POLY(16'h1021), .CRC_INIT(16'h0000)
    ) dut0 (
        .clk(clk), .rstn(rstn), .start(s0), .mode(m0), .payload(p0),
        .busy(b0), .serial_valid(v0), .serial_out(o0), .crc_value(c0), .done_tick(d0)
    );

    crc_frame_serializer dut1 (
        .clk(clk), .rstn(rstn), .start(s1), .mode(m1), .payload(p1),
        .busy(b1), .serial_valid(v1), .serial_out(o1), .crc_value(c1), .done_tick(d1)
    );

    always_comb begin
        obs_vec = sel ? {v1, b1, d1, o1} : {v0, b0, d0, o0};
        obs_crc = sel ? c1 : c0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic [31:0] p, input logic m);
        if (sel) begin
            s1 = s; p1 = p; m1 = m;
        end else begin
            s0 = s; p0 = p; m0 = m;
        end
    endtask

    // Reference frame: [preamble] + payload MSB first + [CRC MSB first]; CRC over payload only.
    task automatic build(input logic [31:0] p, input logic m, input logic [15:0] init);
        logic [31:0] c;
        logic [7:0]  pre;
        pre = 8'hA5;
        exp_bits.delete();
        if (HDR != 0) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(pre[i]);
        end
        c = 32'(init);
        for (int i = 31; i >= 0; i--) begin
            exp_bits.push_back(p[i]);
            c = crc_step(c, p[i], 32'h1021, 16);
        end
        exp_crc = c[15:0];
        if (m) begin
            for (int i = 15; i >= 0; i--) exp_bits.push_back(exp_crc[i]);
        end
    endtask

    // Call just before the accept edge (start/payload/mode already driven).
    task automatic run_frame(input logic [31:0] p, input logic m, input logic [15:0] init,
                             input logic keep, input logic [31:0] np, input logic nm);
        int len;
        build(p, m, init);
        len = exp_bits.size();
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (c <= len) begin
                chk($sformatf("bit%0d", c), 32'(obs_vec), {28'd0, 3'b110, exp_bits[c-1]});
                set_in(keep ? 1'b1 : 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            end else begin
                chk("done", 32'(obs_vec), 32'b0010);
                chk("crc", 32'(obs_crc), 32'(exp_crc));
                if (keep) set_in(1'b1, np, nm);
                else      set_in(1'b0, $urandom, 1'b0);
            end
        end
    endtask

    initial begin
        logic [31:0] p, np;
        logic        m, nm;

        rstn = 1'b0; sel = 1'b0;
        s0 = 1'b0; m0 = 1'b0; p0 = '0;
        s1 = 1'b0; m1 = 1'b0; p1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_vec0", 32'(obs_vec), 32'd0);
        chk("rst_crc0", 32'(obs_crc), 32'd0);
        sel = 1'b1; #1;
        chk("rst_vec1", 32'(obs_vec), 32'd0);
        chk("rst_crc1", 32'(obs_crc), 32'd0);
        #2 rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rel_idle", 32'(obs_vec), 32'd0);
        end

        // Directed, CRC_INIT=0: payload 1 with CRC.
        sel = 1'b0;
        set_in(1'b1, 32'h0000_0001, 1'b1);
        run_frame(32'h0000_0001, 1'b1, 16'h0000, 1'b0, 32'd0, 1'b0);
        chk("crcA_lit", 32'(obs_crc), 32'h1021);
        @(negedge clk);
        chk("idleA", 32'(obs_vec), 32'd0);

        // Directed, CRC_INIT=0: zero payload, no CRC.
        set_in(1'b1, 32'h0, 1'b0);
        run_frame(32'h0, 1'b0, 16'h0000, 1'b0, 32'd0, 1'b0);
        chk("crcB_lit", 32'(obs_crc), 32'h0000);
        @(negedge clk);
        chk("idleB", 32'(obs_vec), 32'd0);

        // Random back-to-back frames at defaults, start held high throughout.
        sel = 1'b1;
        p = $urandom; m = 1'($urandom_range(0, 1));
        set_in(1'b1, p, m);
        for (int f = 0; f < 200; f++) begin
            np = $urandom; nm = 1'($urandom_range(0, 1));
            run_frame(p, m, 16'hFFFF, 1'b1, np, nm);
            p = np; m = nm;
        end
        run_frame(p, m, 16'hFFFF, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("idleR", 32'(obs_vec), 32'd0);

        // Reset at data bit 10 aborts the frame without done_tick.
        p = $urandom;
        set_in(1'b1, p, 1'b1);
        for (int c = 1; c <= 10 + HDR; c++) begin
            @(negedge clk);
            chk("pre_rst_valid", 32'(obs_vec[3]), 32'd1);
        end
        set_in(1'b0, 32'd0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_vec", 32'(obs_vec), 32'd0);
        chk("rst_mid_crc", 32'(obs_crc), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'(obs_vec), 32'd0);
        #2 rstn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(obs_vec), 32'd0);
        end
        p = $urandom; m = 1'($urandom_range(0, 1));
        set_in(1'b1, p, m);
        run_frame(p, m, 16'hFFFF, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("idleF", 32'(obs_vec), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
